// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main controller: states, opcodes,
// funct codes and ALU control values.
package mips_ctrl_pkg;

  localparam logic [3:0] FETCH   = 4'd0;
  localparam logic [3:0] DECODE  = 4'd1;
  localparam logic [3:0] MEMADR  = 4'd2;
  localparam logic [3:0] MEMRD   = 4'd3;
  localparam logic [3:0] MEMWB   = 4'd4;
  localparam logic [3:0] MEMWR   = 4'd5;
  localparam logic [3:0] RTYPEEX = 4'd6;
  localparam logic [3:0] RTYPEWB = 4'd7;
  localparam logic [3:0] BREX    = 4'd8;
  localparam logic [3:0] ADDIEX  = 4'd9;
  localparam logic [3:0] ORIEX   = 4'd10;
  localparam logic [3:0] LUIEX   = 4'd11;
  localparam logic [3:0] IWB     = 4'd12;
  localparam logic [3:0] JEX     = 4'd13;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_SLT  = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/ctrl_aludec.sv
// R-type funct field to 3-bit ALU control. Unknown functs fall back to ADD.
module ctrl_aludec
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alucont
);

  always_comb begin
    alucont = ALU_ADD;
    unique case (funct)
      F_ADD, F_ADDU: alucont = ALU_ADD;
      F_SUB, F_SUBU: alucont = ALU_SUB;
      F_AND:         alucont = ALU_AND;
      F_OR:          alucont = ALU_OR;
      F_SLT:         alucont = ALU_SLT;
      default:       alucont = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore main controller for the multicycle MIPS datapath. Write strobes and the
// PC enable are gated off while reset is high so an aborted instruction writes nothing.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic               pcen,
  output logic               iord,
  output logic               memwrite,
  output logic               irwrite,
  output logic               regdst,
  output logic               memtoreg,
  output logic               regwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [2:0]         alucont,
  output logic               signext,
  output logic               shiftl16,
  output logic [STATE_W-1:0] state
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [2:0]         rtype_alucont;
  logic               pcwrite, branch, irwrite_s, regwrite_s, memwrite_s, bne_sel;

  ctrl_aludec u_aludec (
    .funct   (funct),
    .alucont (rtype_alucont)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = FETCH;
    unique case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        unique case (op)
          OP_LW, OP_SW:      state_d = MEMADR;
          OP_RTYPE:          state_d = RTYPEEX;
          OP_BEQ, OP_BNE:    state_d = BREX;
          OP_ADDI, OP_ADDIU: state_d = ADDIEX;
          OP_ORI:            state_d = ORIEX;
          OP_LUI:            state_d = LUIEX;
          OP_J:              state_d = JEX;
          default:           state_d = FETCH;
        endcase
      end
      MEMADR:  state_d = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   state_d = MEMWB;
      RTYPEEX: state_d = RTYPEWB;
      ADDIEX, ORIEX, LUIEX: state_d = IWB;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    iord       = 1'b0;
    memwrite_s = 1'b0;
    irwrite_s  = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite_s = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    alucont    = ALU_AND;
    signext    = 1'b0;
    shiftl16   = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    unique case (state_q)
      FETCH: begin
        alusrcb   = 2'b01;
        alucont   = ALU_ADD;
        irwrite_s = 1'b1;
        pcwrite   = 1'b1;
      end
      // Branch target is computed here while the opcode is still being decoded.
      DECODE: begin
        alusrcb = 2'b11;
        alucont = ALU_ADD;
        signext = 1'b1;
      end
      MEMADR, ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        signext = 1'b1;
        alucont = ALU_ADD;
      end
      MEMRD: iord = 1'b1;
      MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_s = 1'b1;
      end
      MEMWR: begin
        iord       = 1'b1;
        memwrite_s = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        alucont = rtype_alucont;
      end
      RTYPEWB: begin
        regdst     = 1'b1;
        regwrite_s = 1'b1;
      end
      BREX: begin
        alusrca = 1'b1;
        alucont = ALU_SUB;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      ORIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        alucont = ALU_OR;
      end
      // LUI relies on rs=$0, so OR-ing the shifted immediate into A yields imm<<16.
      LUIEX: begin
        alusrca  = 1'b1;
        alusrcb  = 2'b10;
        shiftl16 = 1'b1;
        alucont  = ALU_OR;
      end
      IWB: regwrite_s = 1'b1;
      JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign bne_sel  = (op == OP_BNE);
  assign pcen     = ~reset & (pcwrite | (branch & (zero ^ bne_sel)));
  assign irwrite  = ~reset & irwrite_s;
  assign regwrite = ~reset & regwrite_s;
  assign memwrite = ~reset & memwrite_s;
  assign state    = state_q;

endmodule
